ahb_resp_mux: RTL

- Slave-to-master return path of the AHB interconnect; the counterpart to the address decoder.
- Registers the decoder's HSEL0..HSEL2 during the address phase. During the following data phase, routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master.
- Contains the built-in default slave for the unmapped region (HADDR[31:30]=2'b11). It returns a two-cycle ERROR response to active transfers there.

---
 rtl/ahb_resp_mux.sv | 111 +++++++++++
 1 files changed

// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master return path: registers the decoder selects for the data phase,
// routes the owning slave's response to the master, and hosts the unmapped-region default slave.
module ahb_resp_mux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL0,
  input  logic                  HSEL1,
  input  logic                  HSEL2,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HRDATA0,
  input  logic [DATA_WIDTH-1:0] HRDATA1,
  input  logic [DATA_WIDTH-1:0] HRDATA2,
  input  logic                  HREADYOUT0,
  input  logic                  HREADYOUT1,
  input  logic                  HREADYOUT2,
  input  logic                  HRESP0,
  input  logic                  HRESP1,
  input  logic                  HRESP2,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [2:0]            dsel_dbg_o,
  output logic [1:0]            dstate_dbg_o
);

  // Handshake: the address phase on HSEL*/HTRANS is accepted only on an edge where
  // HREADY=1; while HREADY=0 the data-phase owner and the error sequence are held.
  typedef enum logic [2:0] {SEL_NONE, SEL_S0, SEL_S1, SEL_S2, SEL_DEF} dsel_t;
  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

  dsel_t   dsel_q, dsel_d, dsel_next;
  dstate_t dstate_q, dstate_d;
  logic    hready_int;
  logic    unused_htrans;

  assign unused_htrans = HTRANS[0];

  // Priority only matters if the decoder ever drives more than one select.
  always_comb begin
    dsel_next = SEL_NONE;
    if (HSEL0)          dsel_next = SEL_S0;
    else if (HSEL1)     dsel_next = SEL_S1;
    else if (HSEL2)     dsel_next = SEL_S2;
    else if (HTRANS[1]) dsel_next = SEL_DEF;
  end

  always_comb begin
    dsel_d = dsel_q;
    if (hready_int) dsel_d = dsel_next;
  end

  always_comb begin
    dstate_d = dstate_q;
    unique case (dstate_q)
      D_IDLE:  if (hready_int && dsel_next == SEL_DEF) dstate_d = D_ERR1;
      D_ERR1:  dstate_d = D_ERR2;
      D_ERR2:  dstate_d = (hready_int && dsel_next == SEL_DEF) ? D_ERR1 : D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q   <= SEL_NONE;
      dstate_q <= D_IDLE;
    end else begin
      dsel_q   <= dsel_d;
      dstate_q <= dstate_d;
    end
  end

  always_comb begin
    HRDATA     = '0;
    hready_int = 1'b1;
    HRESP      = 1'b0;
    unique case (dsel_q)
      SEL_S0: begin
        HRDATA     = HRDATA0;
        hready_int = HREADYOUT0;
        HRESP      = HRESP0;
      end
      SEL_S1: begin
        HRDATA     = HRDATA1;
        hready_int = HREADYOUT1;
        HRESP      = HRESP1;
      end
      SEL_S2: begin
        HRDATA     = HRDATA2;
        hready_int = HREADYOUT2;
        HRESP      = HRESP2;
      end
      SEL_DEF: begin
        // D_IDLE with DEF owning the data phase cannot occur; treat it as OKAY.
        hready_int = (dstate_q != D_ERR1);
        HRESP      = (dstate_q != D_IDLE);
      end
      default: begin
        HRDATA     = '0;
        hready_int = 1'b1;
        HRESP      = 1'b0;
      end
    endcase
  end

  assign HREADY       = hready_int;
  assign dsel_dbg_o   = dsel_q;
  assign dstate_dbg_o = dstate_q;

endmodule
